prog_counter_fetch: RTL and testbench

Program-counter and next-address unit for the extended single-cycle CPU. It holds the current instruction address, drives the program memory address bus, and computes the next PC for sequential fetch, absolute and conditional jumps, and subroutine call and return. Call and return use a hardware return-address stack. It sits directly upstream of the program memory: `pc` feeds the memory's 10-bit address input, and the decoder consumes the 32-bit word read back in the same cycle.

---
 rtl/prog_counter_fetch_if.sv | 30 +++
 rtl/prog_counter_fetch.sv | 97 +++++++++
 tb/tb_prog_counter_fetch.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/prog_counter_fetch_if.sv
// Control strobes from the decoder/datapath into the PC unit, and the PC,
// stack pointer and sticky stack-error flags it returns.
interface prog_counter_fetch_if #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 8
);
    localparam int SP_W = $clog2(DEPTH) + 1;

    logic            stall;
    logic            jump;
    logic            jump_cond;
    logic            zero;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
    logic [SP_W-1:0] sp;
    logic            stack_ovf;
    logic            stack_unf;

    modport master (
        output stall, jump, jump_cond, zero, call, ret, target,
        input  pc, sp, stack_ovf, stack_unf
    );

    modport slave (
        input  stall, jump, jump_cond, zero, call, ret, target,
        output pc, sp, stack_ovf, stack_unf
    );
endinterface

// File: rtl/prog_counter_fetch.sv
// Program counter and next-address selection with a hardware return-address
// stack for call/ret. pc is registered and drives program memory directly.
module prog_counter_fetch #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 8
) (
    input logic                  clk,
    input logic                  reset_n,
    prog_counter_fetch_if.slave  bus
);
    localparam int              ADDR_W  = $clog2(DEPTH);
    localparam int              SP_W    = ADDR_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic [PC_W-1:0]   pc_inc;
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;
    logic              push_en;
    logic [PC_W-1:0]   stack_q [DEPTH];
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic              stack_empty;
    logic              stack_full;
    logic              jump_taken;

    // Wraps modulo 2^PC_W; a call at the last address pushes 0.
    assign pc_inc      = pc_q + PC_W'(1);
    assign wr_idx      = sp_q[ADDR_W-1:0];
    assign rd_idx      = wr_idx - ADDR_W'(1);
    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SP_FULL);
    assign jump_taken  = bus.jump & (~bus.jump_cond | bus.zero);

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (!bus.stall) begin
            if (bus.ret) begin
                if (!stack_empty) begin
                    pc_d = stack_q[rd_idx];
                    sp_d = sp_q - SP_W'(1);
                end else begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end
            end else if (bus.call) begin
                pc_d = bus.target;
                if (!stack_full) begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SP_W'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (jump_taken) begin
                pc_d = bus.target;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= '0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else if (push_en) begin
            stack_q[wr_idx] <= pc_inc;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.sp        = sp_q;
    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;
endmodule

// File: tb/tb_prog_counter_fetch.sv
// Self-checking bench for prog_counter_fetch: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_prog_counter_fetch;
    localparam int PC_W  = 10;
    localparam int DEPTH = 8;
    localparam int PCMOD = 1 << PC_W;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    prog_counter_fetch_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    prog_counter_fetch #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: PC as an integer, return addresses in a queue.
    int m_pc;
    int m_stack[$];
    bit m_ovf;
    bit m_unf;

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic idle();
        bus.stall = 0; bus.jump = 0; bus.jump_cond = 0; bus.zero = 0;
        bus.call = 0; bus.ret = 0; bus.target = '0;
    endtask

    // Apply the current strobes to the model, then advance one clock.
    task automatic tick();
        if (reset_n && !bus.stall) begin
            if (bus.ret) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin m_pc = (m_pc + 1) % PCMOD; m_unf = 1; end
            end else if (bus.call) begin
                if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % PCMOD);
                else m_ovf = 1;
                m_pc = int'(bus.target);
            end else if (bus.jump && (!bus.jump_cond || bus.zero)) begin
                m_pc = int'(bus.target);
            end else begin
                m_pc = (m_pc + 1) % PCMOD;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_jump(input int t);
        idle(); bus.jump = 1; bus.target = PC_W'(t); tick(); idle();
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.pc !== 10'd0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", bus.pc); end
        checks++; if (bus.sp !== 4'd0) begin failures++; $display("FAIL reset_sp got=%0d exp=0", bus.sp); end
        checks++; if (bus.stack_ovf !== 1'b0 || bus.stack_unf !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", bus.stack_ovf, bus.stack_unf); end
        reset_n = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (bus.pc !== PC_W'(i)) begin failures++; $display("FAIL seq_pc got=%0h exp=%0h", bus.pc, i); end
        end
        // Push one entry so the asynchronous reset has sp to clear.
        bus.call = 1; bus.target = 10'h0AA; tick(); idle();
        #3;
        reset_n = 0;
        #1;
        checks++; if (bus.pc !== 10'd0 || bus.sp !== 4'd0) begin failures++; $display("FAIL async_reset got pc=%0h sp=%0d exp pc=0 sp=0", bus.pc, bus.sp); end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1;
        tick();
        checks++; if (bus.pc !== 10'd1) begin failures++; $display("FAIL post_reset_pc got=%0h exp=1", bus.pc); end
    endtask

    task automatic test_wrap_jumps();
        do_jump(10'h3FF);
        checks++; if (bus.pc !== 10'h3FF) begin failures++; $display("FAIL jump_3ff got=%0h exp=3ff", bus.pc); end
        tick();
        checks++; if (bus.pc !== 10'h000) begin failures++; $display("FAIL wrap_pc got=%0h exp=0", bus.pc); end
        checks++; if (bus.stack_ovf !== 1'b0 || bus.stack_unf !== 1'b0) begin failures++; $display("FAIL wrap_flags got=%b%b exp=00", bus.stack_ovf, bus.stack_unf); end
        bus.jump = 1; bus.jump_cond = 1; bus.zero = 0; bus.target = 10'h200; tick();
        checks++; if (bus.pc !== 10'h001) begin failures++; $display("FAIL cond_not_taken got=%0h exp=1", bus.pc); end
        bus.zero = 1; tick();
        checks++; if (bus.pc !== 10'h200) begin failures++; $display("FAIL cond_taken got=%0h exp=200", bus.pc); end
        bus.jump_cond = 0; bus.zero = 0; bus.target = 10'h3FF; tick(); idle();
        checks++; if (bus.pc !== 10'h3FF) begin failures++; $display("FAIL uncond_jump got=%0h exp=3ff", bus.pc); end
    endtask

    task automatic test_call_ret();
        do_jump(10'h010);
        bus.call = 1; bus.target = 10'h100; tick(); idle();
        checks++; if (bus.pc !== 10'h100 || bus.sp !== 4'd1) begin failures++; $display("FAIL call1 got pc=%0h sp=%0d exp pc=100 sp=1", bus.pc, bus.sp); end
        repeat (5) tick();
        bus.call = 1; bus.target = 10'h180; tick(); idle();
        checks++; if (bus.pc !== 10'h180 || bus.sp !== 4'd2) begin failures++; $display("FAIL call2 got pc=%0h sp=%0d exp pc=180 sp=2", bus.pc, bus.sp); end
        bus.ret = 1; tick();
        checks++; if (bus.pc !== 10'h106 || bus.sp !== 4'd1) begin failures++; $display("FAIL ret1 got pc=%0h sp=%0d exp pc=106 sp=1", bus.pc, bus.sp); end
        tick(); idle();
        checks++; if (bus.pc !== 10'h011 || bus.sp !== 4'd0) begin failures++; $display("FAIL ret2 got pc=%0h sp=%0d exp pc=11 sp=0", bus.pc, bus.sp); end
    endtask

    task automatic test_underflow_priority();
        do_jump(10'h020);
        bus.ret = 1; tick(); idle();
        checks++; if (bus.pc !== 10'h021 || bus.stack_unf !== 1'b1) begin failures++; $display("FAIL unf_ret got pc=%0h unf=%b exp pc=21 unf=1", bus.pc, bus.stack_unf); end
        repeat (10) tick();
        checks++; if (bus.stack_unf !== 1'b1 || bus.sp !== 4'd0) begin failures++; $display("FAIL unf_sticky got unf=%b sp=%0d exp unf=1 sp=0", bus.stack_unf, bus.sp); end
        bus.call = 1; bus.target = 10'h050; tick();
        bus.target = 10'h060; tick(); idle();
        bus.call = 1; bus.ret = 1; bus.jump = 1; bus.target = 10'h2AA; tick(); idle();
        checks++; if (bus.pc !== 10'h051 || bus.sp !== 4'd1) begin failures++; $display("FAIL strobe_priority got pc=%0h sp=%0d exp pc=51 sp=1", bus.pc, bus.sp); end
        bus.ret = 1; tick(); idle();
        checks++; if (bus.pc !== 10'h02C || bus.sp !== 4'd0) begin failures++; $display("FAIL drain_ret got pc=%0h sp=%0d exp pc=2c sp=0", bus.pc, bus.sp); end
    endtask

    task automatic test_overflow();
        int pushed[DEPTH];
        int t;
        for (int i = 0; i < DEPTH; i++) begin
            pushed[i] = (m_pc + 1) % PCMOD;
            t = $urandom_range(0, PCMOD - 1);
            bus.call = 1; bus.target = PC_W'(t); tick();
        end
        checks++; if (bus.sp !== 4'd8 || bus.stack_ovf !== 1'b0) begin failures++; $display("FAIL full_stack got sp=%0d ovf=%b exp sp=8 ovf=0", bus.sp, bus.stack_ovf); end
        bus.target = 10'h3FF; tick(); idle();
        checks++; if (bus.pc !== 10'h3FF || bus.sp !== 4'd8 || bus.stack_ovf !== 1'b1) begin failures++; $display("FAIL ovf_call got pc=%0h sp=%0d ovf=%b exp pc=3ff sp=8 ovf=1", bus.pc, bus.sp, bus.stack_ovf); end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            bus.ret = 1; tick();
            checks++; if (bus.pc !== PC_W'(pushed[i]) || bus.sp !== 4'(i)) begin failures++; $display("FAIL lifo_ret%0d got pc=%0h sp=%0d exp pc=%0h sp=%0d", i, bus.pc, bus.sp, pushed[i], i); end
        end
        idle();
    endtask

    task automatic test_stall();
        do_jump(10'h040);
        bus.stall = 1; bus.call = 1; bus.target = 10'h123;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc !== 10'h040 || bus.sp !== 4'd0) begin failures++; $display("FAIL stall_hold got pc=%0h sp=%0d exp pc=40 sp=0", bus.pc, bus.sp); end
        end
        bus.stall = 0; tick(); idle();
        checks++; if (bus.pc !== 10'h123 || bus.sp !== 4'd1) begin failures++; $display("FAIL stall_release got pc=%0h sp=%0d exp pc=123 sp=1", bus.pc, bus.sp); end
    endtask

    task automatic test_random();
        reset_n = 0; idle(); model_reset();
        @(posedge clk); #1;
        reset_n = 1;
        for (int n = 0; n < 400; n++) begin
            bus.stall     = ($urandom_range(0, 7) == 0);
            bus.ret       = ($urandom_range(0, 3) == 0);
            bus.call      = ($urandom_range(0, 2) == 0);
            bus.jump      = ($urandom_range(0, 2) == 0);
            bus.jump_cond = 1'($urandom_range(0, 1));
            bus.zero      = 1'($urandom_range(0, 1));
            bus.target    = PC_W'($urandom_range(0, PCMOD - 1));
            tick();
            checks++; if (bus.pc !== PC_W'(m_pc) || bus.sp !== 4'(m_stack.size()) || bus.stack_ovf !== m_ovf || bus.stack_unf !== m_unf) begin
                failures++;
                $display("FAIL random_%0d got pc=%0h sp=%0d ovf=%b unf=%b exp pc=%0h sp=%0d ovf=%b unf=%b", n, bus.pc, bus.sp, bus.stack_ovf, bus.stack_unf, m_pc, m_stack.size(), m_ovf, m_unf);
            end
        end
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_wrap_jumps();
        test_call_ret();
        test_underflow_priority();
        test_overflow();
        test_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
